// File: rtl/spi_master.sv
// Single-word SPI master: all four CPOL/CPHA modes, MSB- or LSB-first, start/busy/done handshake.
// Optional build macro SPI_MASTER_LOOPBACK_EN adds a loopback input that samples mosi instead of miso.
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  cpol,
  input  logic                  cpha,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic                  loopback,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TOG_W = $clog2(2 * DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [TOG_W-1:0]      tog_reg, tog_next;
  logic [DATA_WIDTH-1:0] tx_sh_reg, tx_sh_next;
  logic [DATA_WIDTH-1:0] rx_sh_reg, rx_sh_next;
  logic [DATA_WIDTH-1:0] rx_data_next;
  logic                  cpha_reg, cpha_next;
  logic                  sclk_next, cs_n_next, mosi_next, busy_next, done_next;

  logic                  sample_bit, first_bit, tx_bit, leading, cnt_wrap;
  logic [DATA_WIDTH-1:0] tx_load_sh, tx_shifted, rx_shifted;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign sample_bit = loopback ? mosi : miso;
`else
  assign sample_bit = miso;
`endif

  // Transmit and receive share one ordering rule.
  always_comb begin
    if (MSB_FIRST) begin
      first_bit  = tx_data[DATA_WIDTH-1];
      tx_load_sh = {tx_data[DATA_WIDTH-2:0], 1'b0};
      tx_bit     = tx_sh_reg[DATA_WIDTH-1];
      tx_shifted = {tx_sh_reg[DATA_WIDTH-2:0], 1'b0};
      rx_shifted = {rx_sh_reg[DATA_WIDTH-2:0], sample_bit};
    end else begin
      first_bit  = tx_data[0];
      tx_load_sh = {1'b0, tx_data[DATA_WIDTH-1:1]};
      tx_bit     = tx_sh_reg[0];
      tx_shifted = {1'b0, tx_sh_reg[DATA_WIDTH-1:1]};
      rx_shifted = {sample_bit, rx_sh_reg[DATA_WIDTH-1:1]};
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    tog_next     = tog_reg;
    tx_sh_next   = tx_sh_reg;
    rx_sh_next   = rx_sh_reg;
    rx_data_next = rx_data;
    cpha_next    = cpha_reg;
    sclk_next    = sclk;
    cs_n_next    = cs_n;
    mosi_next    = mosi;
    busy_next    = busy;
    done_next    = 1'b0;
    cnt_wrap     = (cnt_reg == CNT_LAST);
    leading      = ~tog_reg[0];

    case (state_reg)
      IDLE: begin
        sclk_next = cpol;
        cs_n_next = 1'b1;
        if (start) begin
          state_next = SETUP;
          cnt_next   = '0;
          tog_next   = '0;
          cs_n_next  = 1'b0;
          busy_next  = 1'b1;
          cpha_next  = cpha;
          rx_sh_next = '0;
          // CPHA=0 presents the first bit before the first sclk edge.
          if (cpha) begin
            tx_sh_next = tx_data;
          end else begin
            mosi_next  = first_bit;
            tx_sh_next = tx_load_sh;
          end
        end
      end
      SETUP: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_wrap) begin
          cnt_next   = '0;
          state_next = XFER;
        end
      end
      XFER: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_wrap) begin
          cnt_next  = '0;
          sclk_next = ~sclk;
          tog_next  = tog_reg + 1'b1;
          // Sample edge is leading for CPHA=0, trailing for CPHA=1; the other edge shifts.
          if (leading == ~cpha_reg) begin
            rx_sh_next = rx_shifted;
          end else if (leading || (tog_reg != TOG_LAST)) begin
            mosi_next  = tx_bit;
            tx_sh_next = tx_shifted;
          end
          if (tog_reg == TOG_LAST) begin
            tog_next   = '0;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_wrap) begin
          cnt_next     = '0;
          cs_n_next    = 1'b1;
          done_next    = 1'b1;
          rx_data_next = rx_sh_reg;
          state_next   = GAP;
        end
      end
      GAP: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_wrap) begin
          cnt_next   = '0;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      tog_reg   <= '0;
      tx_sh_reg <= '0;
      rx_sh_reg <= '0;
      rx_data   <= '0;
      cpha_reg  <= 1'b0;
      sclk      <= 1'b0;
      cs_n      <= 1'b1;
      mosi      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      tog_reg   <= tog_next;
      tx_sh_reg <= tx_sh_next;
      rx_sh_reg <= rx_sh_next;
      rx_data   <= rx_data_next;
      cpha_reg  <= cpha_next;
      sclk      <= sclk_next;
      cs_n      <= cs_n_next;
      mosi      <= mosi_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: behavioural SPI slave, expected-word scoreboard, one task per scenario.
// A second instance (LSB-first, mosi looped to miso) covers bit ordering.
module tb_spi_master;
  localparam int DW = 8;
  localparam int CD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          busy, done, sclk, cs_n, mosi, miso;
  logic [DW-1:0] rx_data;
  logic          lb_zero = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic          lb = 1'b0;
`endif

  logic          start_l = 1'b0, cpol_l = 1'b0, cpha_l = 1'b0;
  logic [DW-1:0] tx_l = '0;
  logic          busy_l, done_l, sclk_l, cs_n_l, mosi_l, miso_l;
  logic [DW-1:0] rx_l;

  spi_master #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .cpol(cpol), .cpha(cpha),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(lb),
`endif
    .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk), .cs_n(cs_n),
    .mosi(mosi), .miso(miso)
  );

  spi_master #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0), .CLK_DIV(CD)) dut_l (
    .clk(clk), .rst(rst), .start(start_l), .tx_data(tx_l), .cpol(cpol_l), .cpha(cpha_l),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .busy(busy_l), .done(done_l), .rx_data(rx_l), .sclk(sclk_l), .cs_n(cs_n_l),
    .mosi(mosi_l), .miso(miso_l)
  );

  assign miso_l = mosi_l;

  // Behavioural MSB-first slave, evaluated on the falling clk edge.
  logic [DW-1:0] s_tx = '0, s_sh = '0, s_rx = '0, s_word = '0;
  logic          s_cpol = 1'b0, s_cpha = 1'b0, s_miso = 1'b0;
  logic          cs_prev = 1'b1, sclk_prev = 1'b0;
  int            s_valid_cnt = 0;

  assign miso = lb_zero ? 1'b0 : s_miso;

  always @(negedge clk) begin
    if (cs_prev && !cs_n) begin
      s_sh = s_tx;
      s_rx = '0;
      if (!s_cpha) begin
        s_miso = s_sh[DW-1];
        s_sh   = {s_sh[DW-2:0], 1'b0};
      end
    end else if (!cs_n && (sclk !== sclk_prev)) begin
      if ((sclk != s_cpol) == !s_cpha) begin
        s_rx = {s_rx[DW-2:0], mosi};
      end else begin
        s_miso = s_sh[DW-1];
        s_sh   = {s_sh[DW-2:0], 1'b0};
      end
    end
    if (!cs_prev && cs_n) begin
      s_word = s_rx;
      s_valid_cnt++;
    end
    cs_prev   = cs_n;
    sclk_prev = sclk;
  end

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_rx = '0;

  task automatic run_xfer(input logic [DW-1:0] tx, input logic [DW-1:0] stx,
                          input logic pol, input logic pha,
                          output bit ok, output logic [DW-1:0] got);
    tx_data = tx; cpol = pol; cpha = pha;
    s_tx = stx; s_cpol = pol; s_cpha = pha;
    ok = 1'b0; got = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ok = 1'b1;
        got = rx_data;
        break;
      end
    end
    for (int i = 0; i < 50 && busy; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    cpol = 1'b1;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", sclk); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", mosi); end
    checks++; if (rx_data !== '0) begin errors++; $display("FAIL reset_rx got %h want 00", rx_data); end
    cpol = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    int cs_cyc = -1, done_cyc = -1, busy_cyc = -1, cyc;
    logic [DW-1:0] got = '0, exp;
    int vc;
    logic done_after = 1'b1;
    tx_data = 8'hA5; cpol = 1'b0; cpha = 1'b0;
    s_tx = 8'h3C; s_cpol = 1'b0; s_cpha = 1'b0;
    vc = s_valid_cnt;
    exp_q.push_back(8'h3C);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    if (cs_n === 1'b0) cs_cyc = 1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy_c1 got %b want 1", busy); end
    while (cyc < 100 && busy_cyc < 0) begin
      @(posedge clk); #1;
      cyc++;
      if (cs_cyc < 0 && cs_n === 1'b0) cs_cyc = cyc;
      if (done_cyc < 0 && done === 1'b1) begin done_cyc = cyc; got = rx_data; end
      if (done_cyc > 0 && cyc == done_cyc + 1) done_after = done;
      if (busy === 1'b0) busy_cyc = cyc;
    end
    exp = exp_q.pop_front();
    $display("xfer latency rx %h cs_low %0d done %0d busy_low %0d", got, cs_cyc, done_cyc, busy_cyc);
    checks++; if (cs_cyc != 1) begin errors++; $display("FAIL lat_cs_low got %0d want 1", cs_cyc); end
    checks++; if (done_cyc != 1 + CD*(2*DW+2)) begin errors++; $display("FAIL lat_done got %0d want %0d", done_cyc, 1 + CD*(2*DW+2)); end
    checks++; if (busy_cyc != 1 + CD*(2*DW+3)) begin errors++; $display("FAIL lat_busy_low got %0d want %0d", busy_cyc, 1 + CD*(2*DW+3)); end
    checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL lat_done_width got %b want 0", done_after); end
    checks++; if (got !== exp) begin errors++; $display("FAIL lat_rx got %h want %h", got, exp); end
    checks++; if (s_valid_cnt != vc + 1 || s_word !== 8'hA5) begin errors++; $display("FAIL lat_slave_rx got %h want a5", s_word); end
    last_rx = exp;
  endtask

  task automatic test_modes();
    bit ok;
    logic [DW-1:0] got, exp;
    int vc;
    for (int m = 0; m < 4; m++) begin
      vc = s_valid_cnt;
      exp_q.push_back(8'h3C);
      run_xfer(8'hA5, 8'h3C, m[1], m[0], ok, got);
      exp = exp_q.pop_front();
      $display("xfer mode %0d rx %h slave %h", m, got, s_word);
      checks++; if (!ok || got !== exp) begin errors++; $display("FAIL mode%0d_rx got %h want %h done_seen %0d", m, got, exp, ok); end
      checks++; if (s_valid_cnt != vc + 1 || s_word !== 8'hA5) begin errors++; $display("FAIL mode%0d_slave_rx got %h want a5", m, s_word); end
      checks++; if (sclk !== m[1]) begin errors++; $display("FAIL mode%0d_sclk_idle got %b want %b", m, sclk, m[1]); end
      last_rx = exp;
    end
  endtask

  task automatic test_order();
    logic [DW-1:0] txv[2] = '{8'h01, 8'hB2};
    logic [DW-1:0] seq, got, exp;
    logic prev;
    int nb;
    bit ok;
    for (int t = 0; t < 2; t++) begin
      tx_l = txv[t]; cpol_l = 1'b1; cpha_l = (t == 1);
      @(posedge clk); #1;
      checks++; if (sclk_l !== 1'b1) begin errors++; $display("FAIL order%0d_idle_before got %b want 1", t, sclk_l); end
      exp_q.push_back(txv[t]);
      start_l = 1'b1;
      @(posedge clk); #1;
      start_l = 1'b0;
      prev = sclk_l; nb = 0; seq = '0; ok = 1'b0; got = '0;
      for (int i = 0; i < 200; i++) begin
        @(posedge clk); #1;
        if (sclk_l !== prev) begin
          if ((sclk_l != cpol_l) == !cpha_l) begin
            if (nb < DW) seq[nb] = mosi_l;
            nb++;
          end
          prev = sclk_l;
        end
        if (done_l) begin ok = 1'b1; got = rx_l; break; end
      end
      for (int i = 0; i < 50 && busy_l; i++) begin @(posedge clk); #1; end
      exp = exp_q.pop_front();
      $display("xfer lsb_first %0d tx %h rx %h bits %h", t, txv[t], got, seq);
      checks++; if (nb != DW || seq !== txv[t]) begin errors++; $display("FAIL order%0d_mosi_bits got %h (%0d) want %h", t, seq, nb, txv[t]); end
      checks++; if (!ok || got !== exp) begin errors++; $display("FAIL order%0d_rx got %h want %h", t, got, exp); end
      checks++; if (sclk_l !== 1'b1) begin errors++; $display("FAIL order%0d_idle_after got %b want 1", t, sclk_l); end
    end
    cpol_l = 1'b0; cpha_l = 1'b0;
  endtask

  task automatic test_abort();
    int ndone = 0;
    bit ok;
    logic [DW-1:0] got, exp;
    int vc;
    tx_data = 8'h96; cpol = 1'b1; cpha = 1'b1;
    s_tx = 8'h69; s_cpol = 1'b1; s_cpha = 1'b1;
    exp_q.push_back(8'h69);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (1 + CD + 8*CD) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_front());
    $display("xfer abort cs_n %b sclk %b busy %b", cs_n, sclk, busy);
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL abort_cs_n got %b want 1", cs_n); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL abort_sclk got %b want 0", sclk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    for (int i = 0; i < 60; i++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", ndone); end
    checks++; if (rx_data !== '0) begin errors++; $display("FAIL abort_rx got %h want 00", rx_data); end
    vc = s_valid_cnt;
    exp_q.push_back(8'hC3);
    run_xfer(8'h5A, 8'hC3, 1'b0, 1'b0, ok, got);
    exp = exp_q.pop_front();
    $display("xfer after_abort rx %h slave %h", got, s_word);
    checks++; if (!ok || got !== exp) begin errors++; $display("FAIL abort_next_rx got %h want %h", got, exp); end
    checks++; if (s_valid_cnt != vc + 1 || s_word !== 8'h5A) begin errors++; $display("FAIL abort_next_slave got %h want 5a", s_word); end
    last_rx = exp;
  endtask

  task automatic test_ignore();
    int ndone = 0, nfall = 0, vc;
    logic [DW-1:0] got = '0, exp;
    logic cp;
    tx_data = 8'hA5; cpol = 1'b0; cpha = 1'b0;
    s_tx = 8'h3C; s_cpol = 1'b0; s_cpha = 1'b0;
    vc = s_valid_cnt;
    exp_q.push_back(8'h3C);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cp = cs_n;
    for (int i = 0; i < 150; i++) begin
      if (i == 10) begin start = 1'b1; tx_data = 8'hFF; cpol = 1'b1; cpha = 1'b1; end
      if (i == 13) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin ndone++; got = rx_data; end
      if (cp && !cs_n) nfall++;
      cp = cs_n;
    end
    exp = exp_q.pop_front();
    $display("xfer ignore rx %h dones %0d", got, ndone);
    checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_dones got %0d want 1", ndone); end
    checks++; if (nfall != 0) begin errors++; $display("FAIL ignore_extra_cs got %0d want 0", nfall); end
    checks++; if (got !== exp) begin errors++; $display("FAIL ignore_rx got %h want %h", got, exp); end
    checks++; if (s_valid_cnt != vc + 1 || s_word !== 8'hA5) begin errors++; $display("FAIL ignore_slave got %h want a5", s_word); end
    cpol = 1'b0; cpha = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int n_done = 0, n_win = 0, high_run = 0, min_gap = 1000, cyc = 0, last_done = -1, bad_spacing = 0;
    logic cp = 1'b1;
    logic [DW-1:0] exp;
    tx_data = 8'hA5; cpol = 1'b0; cpha = 1'b0;
    s_tx = 8'h3C; s_cpol = 1'b0; s_cpha = 1'b0;
    repeat (3) exp_q.push_back(8'h3C);
    start = 1'b1;
    for (int i = 0; i < 400 && n_done < 3; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (cp && !cs_n) begin
        if (n_win > 0 && high_run < min_gap) min_gap = high_run;
        n_win++;
      end
      high_run = cs_n ? high_run + 1 : 0;
      cp = cs_n;
      if (done) begin
        exp = exp_q.pop_front();
        n_done++;
        if (last_done >= 0 && cyc - last_done != 1 + CD*(2*DW+3)) bad_spacing++;
        last_done = cyc;
        $display("xfer b2b %0d rx %h slave %h", n_done, rx_data, s_word);
        checks++; if (rx_data !== exp) begin errors++; $display("FAIL b2b_rx%0d got %h want %h", n_done, rx_data, exp); end
        if (n_done == 3) start = 1'b0;
      end
    end
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (cp && !cs_n) n_win++;
      cp = cs_n;
    end
    checks++; if (n_done != 3) begin errors++; $display("FAIL b2b_dones got %0d want 3", n_done); end
    checks++; if (n_win != 3) begin errors++; $display("FAIL b2b_windows got %0d want 3", n_win); end
    checks++; if (min_gap < CD) begin errors++; $display("FAIL b2b_gap got %0d want >=%0d", min_gap, CD); end
    checks++; if (bad_spacing != 0) begin errors++; $display("FAIL b2b_spacing got %0d off-period pairs want 0", bad_spacing); end
    checks++; if (s_word !== 8'hA5) begin errors++; $display("FAIL b2b_slave got %h want a5", s_word); end
  endtask

`ifdef SPI_MASTER_LOOPBACK_EN
  task automatic test_loopback();
    bit ok;
    logic [DW-1:0] got, exp;
    lb = 1'b1; lb_zero = 1'b1;
    exp_q.push_back(8'h5A);
    run_xfer(8'h5A, 8'h00, 1'b0, 1'b0, ok, got);
    exp = exp_q.pop_front();
    $display("xfer loopback rx %h", got);
    checks++; if (!ok || got !== exp) begin errors++; $display("FAIL loopback_rx got %h want %h", got, exp); end
    lb = 1'b0; lb_zero = 1'b0;
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_latency();
    test_modes();
    test_order();
    test_abort();
    test_ignore();
    test_back_to_back();
`ifdef SPI_MASTER_LOOPBACK_EN
    test_loopback();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
